fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 129 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the synchronous FIFO: pops on buffer room, absorbs the
// 1-cycle read latency in a 3-entry skid buffer and presents a valid/ready stream.
package fifo_param_pkg;
    parameter int FIFO_WIDTH = 8;
endpackage

module fifo_rd_stream #(
    parameter int FIFO_WIDTH = fifo_param_pkg::FIFO_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_err,
    input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [FIFO_WIDTH-1:0] DATA_ZERO = {FIFO_WIDTH{1'b0}};

    // Buffer pointers walk 0,1,2,0,...
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        ptr_inc = (p == 2'd2) ? 2'd0 : (p + 2'd1);
    endfunction

    logic [1:0]            occ_r;
    logic [1:0]            head_r;
    logic [1:0]            tail_r;
    logic                  inf_r;
    logic [FIFO_WIDTH-1:0] mem_r [3];
    logic                  m_valid_r;
    logic [FIFO_WIDTH-1:0] m_data_r;
    logic [CNT_WIDTH-1:0]  word_cnt_r;
    logic [CNT_WIDTH-1:0]  err_cnt_r;

    logic [2:0]            room_s;
    logic                  issue_s;
    logic                  push_s;
    logic                  drop_err_s;
    logic                  pop_s;
    logic [1:0]            occ_nxt_s;
    logic [1:0]            head_nxt_s;
    logic [1:0]            tail_nxt_s;
    logic [FIFO_WIDTH-1:0] mem_nxt_s [3];

    // Issue and capture qualifiers; issue looks only at registered occupancy so
    // it never forms a path from m_ready to fifo_rd_en.
    always_comb begin
        room_s     = {1'b0, occ_r} + {2'b00, inf_r};
        issue_s    = en & ~fifo_empty & ~flush & ~rst & (room_s <= 3'd2);
        push_s     = inf_r & ~fifo_rd_err & ~flush;
        drop_err_s = inf_r & fifo_rd_err & ~flush;
        pop_s      = m_valid_r & m_ready;
    end

    // Next buffer state; flush wins over any push or pop in the same cycle.
    always_comb begin
        mem_nxt_s  = mem_r;
        occ_nxt_s  = occ_r;
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        if (flush) begin
            occ_nxt_s  = 2'd0;
            head_nxt_s = 2'd0;
            tail_nxt_s = 2'd0;
        end else begin
            head_nxt_s = pop_s  ? ptr_inc(head_r) : head_r;
            tail_nxt_s = push_s ? ptr_inc(tail_r) : tail_r;
            if (push_s) begin
                mem_nxt_s[tail_r] = fifo_rd_data;
            end else begin
                mem_nxt_s[tail_r] = mem_r[tail_r];
            end
            case ({push_s, pop_s})
                2'b10:   occ_nxt_s = occ_r + 2'd1;
                2'b01:   occ_nxt_s = occ_r - 2'd1;
                default: occ_nxt_s = occ_r;
            endcase
        end
    end

    // State, registered stream outputs and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r      <= 2'd0;
            head_r     <= 2'd0;
            tail_r     <= 2'd0;
            inf_r      <= 1'b0;
            m_valid_r  <= 1'b0;
            m_data_r   <= DATA_ZERO;
            word_cnt_r <= CNT_ZERO;
            err_cnt_r  <= CNT_ZERO;
            for (int i = 0; i < 3; i++) begin
                mem_r[i] <= DATA_ZERO;
            end
        end else begin
            occ_r     <= occ_nxt_s;
            head_r    <= head_nxt_s;
            tail_r    <= tail_nxt_s;
            inf_r     <= issue_s;
            mem_r     <= mem_nxt_s;
            m_valid_r <= (occ_nxt_s != 2'd0);
            m_data_r  <= mem_nxt_s[head_nxt_s];
            if (pop_s) begin
                word_cnt_r <= word_cnt_r + CNT_ONE;
            end
            if (drop_err_s && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end
        end
    end

    assign fifo_rd_en = issue_s;
    assign m_valid    = m_valid_r;
    assign m_data     = m_data_r;
    assign word_cnt   = word_cnt_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO in front.
module tb_fifo_rd_stream;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         flush = 1'b0;
    logic         m_ready = 1'b0;
    logic         fifo_empty;
    logic         fifo_rd_err = 1'b0;
    logic [W-1:0] fifo_rd_data = 8'h00;
    logic         fifo_rd_en;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [15:0]  word_cnt;
    logic [15:0]  err_cnt;
    logic         fifo_rd_en2;
    logic         m_valid2;
    logic [W-1:0] m_data2;
    logic [1:0]   word_cnt2;
    logic [1:0]   err_cnt2;

    int pass_cnt = 0;
    int total_cnt = 0;

    // FIFO model: holds load_n consecutive words starting at load_base
    logic [W-1:0] load_base = 8'h00;
    int           load_n = 0;
    int           load_gen = 0;
    int           load_seen = 0;
    int           rd_ptr = 0;
    int           underflow = 0;
    int           err_mode = 0;
    int           err_sel = 0;
    logic         model_empty = 1'b1;
    logic         force_empty = 1'b0;
    logic         rd_en_smp = 1'b0;
    int           pop_cnt = 0;
    logic [W-1:0] got_mem [128];
    int           got_n = 0;

    assign fifo_empty = model_empty | force_empty;

    fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_rd_err(fifo_rd_err), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .word_cnt(word_cnt), .err_cnt(err_cnt)
    );

    fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_rd_err(fifo_rd_err), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en2),
        .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2),
        .word_cnt(word_cnt2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    // Observe pops and delivered words on the falling edge.
    always @(negedge clk) begin
        rd_en_smp <= fifo_rd_en;
        if (fifo_rd_en) begin
            pop_cnt <= pop_cnt + 1;
        end
        if (m_valid && m_ready) begin
            got_mem[got_n & 127] <= m_data;
            got_n <= got_n + 1;
        end
    end

    // FIFO read port: data and error appear one cycle after the pop.
    always @(posedge clk) begin
        if (load_gen != load_seen) begin
            load_seen   <= load_gen;
            rd_ptr      <= 0;
            model_empty <= (load_n == 0);
            fifo_rd_err <= 1'b0;
        end else if (rd_en_smp) begin
            if (rd_ptr < load_n) begin
                fifo_rd_data <= load_base + 8'(rd_ptr);
            end else begin
                fifo_rd_data <= 8'hEE;
                underflow    <= underflow + 1;
            end
            fifo_rd_err <= (err_mode == 2) || ((err_mode == 1) && (rd_ptr == err_sel));
            rd_ptr      <= rd_ptr + 1;
            model_empty <= (rd_ptr + 1 >= load_n);
        end else begin
            fifo_rd_err <= 1'b0;
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
        end
    endtask

    task automatic do_reset(input logic [W-1:0] base, input int n);
        rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
        force_empty = 1'b0; err_mode = 0;
        load_base = base; load_n = n; load_gen = load_gen + 1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1;
        load_base = 8'h01; load_n = 8; load_gen = load_gen + 1;
        next_cycle();
        sample();
        total_cnt++;
        if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b expected 0", fifo_rd_en);
        else pass_cnt++;
        total_cnt++;
        if ({m_valid, m_data} !== 9'h000) $display("FAIL rst_stream: got v=%b d=%h expected v=0 d=00", m_valid, m_data);
        else pass_cnt++;
        total_cnt++;
        if ({word_cnt, err_cnt} !== 32'h0) $display("FAIL rst_counters: got w=%0d e=%0d expected 0 0", word_cnt, err_cnt);
        else pass_cnt++;
        next_cycle();
        rst = 1'b0;
        sample();
        total_cnt++;
        if (fifo_rd_en !== 1'b1) $display("FAIL rst_release_pop: got %b expected 1", fifo_rd_en);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_streaming;
        int p0;
        int twin_bad;
        logic [11:0] pat;
        logic [W-1:0] exp_d;
        do_reset(8'h11, 8);
        en = 1'b1; m_ready = 1'b1; p0 = pop_cnt; twin_bad = 0; pat = 12'h000;
        for (int c = 0; c < 12; c++) begin
            sample();
            pat[c] = fifo_rd_en;
            if ({fifo_rd_en2, m_valid2, m_data2} !== {fifo_rd_en, m_valid, m_data}) twin_bad++;
            if (c >= 2 && c <= 9) begin
                exp_d = 8'h11 + 8'(c - 2);
                total_cnt++;
                if (m_valid !== 1'b1 || m_data !== exp_d)
                    $display("FAIL stream_word c%0d: got v=%b d=%h expected v=1 d=%h", c, m_valid, m_data, exp_d);
                else pass_cnt++;
            end
            next_cycle();
        end
        total_cnt++;
        if (pat !== 12'h0FF) $display("FAIL stream_pop_pattern: got %h expected 0ff", pat);
        else pass_cnt++;
        total_cnt++;
        if (pop_cnt - p0 !== 8) $display("FAIL stream_pops: got %0d expected 8", pop_cnt - p0);
        else pass_cnt++;
        sample();
        total_cnt++;
        if (word_cnt !== 16'd8 || err_cnt !== 16'd0) $display("FAIL stream_counters: got w=%0d e=%0d expected 8 0", word_cnt, err_cnt);
        else pass_cnt++;
        total_cnt++;
        if (word_cnt2 !== 2'd0) $display("FAIL stream_word_cnt_wrap: got %0d expected 0", word_cnt2);
        else pass_cnt++;
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL stream_drained: got m_valid=%b expected 0", m_valid);
        else pass_cnt++;
        total_cnt++;
        if (twin_bad !== 0) $display("FAIL stream_twin: got %0d differing cycles expected 0", twin_bad);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back_backpressure;
        int p0;
        int g0;
        int stable;
        int bad;
        do_reset(8'h11, 8);
        en = 1'b1; m_ready = 1'b0; p0 = pop_cnt; stable = 0; bad = 0;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (c >= 2 && m_valid === 1'b1 && m_data === 8'h11) stable++;
            next_cycle();
        end
        total_cnt++;
        if (pop_cnt - p0 !== 3) $display("FAIL bp_pops: got %0d expected 3", pop_cnt - p0);
        else pass_cnt++;
        total_cnt++;
        if (stable !== 6) $display("FAIL bp_hold: got %0d stable cycles expected 6", stable);
        else pass_cnt++;
        m_ready = 1'b1; g0 = got_n;
        sample();
        total_cnt++;
        if (fifo_rd_en !== 1'b0) $display("FAIL bp_no_pop_at_handshake: got %b expected 0", fifo_rd_en);
        else pass_cnt++;
        next_cycle();
        sample();
        total_cnt++;
        if (fifo_rd_en !== 1'b1) $display("FAIL bp_pop_after_handshake: got %b expected 1", fifo_rd_en);
        else pass_cnt++;
        run_cycles(20);
        sample();
        total_cnt++;
        if (got_n - g0 !== 8) $display("FAIL bp_count: got %0d words expected 8", got_n - g0);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            if (got_mem[(g0 + k) & 127] !== 8'h11 + 8'(k)) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL bp_order: got %0d misordered words expected 0", bad);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_flush;
        int g0;
        do_reset(8'h21, 8);
        en = 1'b1; m_ready = 1'b0; g0 = got_n;
        run_cycles(3);
        flush = 1'b1;
        sample();
        total_cnt++;
        if (fifo_rd_en !== 1'b0) $display("FAIL flush_no_pop: got %b expected 0", fifo_rd_en);
        else pass_cnt++;
        next_cycle();
        flush = 1'b0; m_ready = 1'b1;
        sample();
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL flush_valid_drop: got %b expected 0", m_valid);
        else pass_cnt++;
        total_cnt++;
        if (word_cnt !== 16'd0 || err_cnt !== 16'd0) $display("FAIL flush_counters: got w=%0d e=%0d expected 0 0", word_cnt, err_cnt);
        else pass_cnt++;
        run_cycles(20);
        sample();
        total_cnt++;
        if (got_n - g0 !== 5 || got_mem[g0 & 127] !== 8'h24)
            $display("FAIL flush_resume: got n=%0d first=%h expected n=5 first=24", got_n - g0, got_mem[g0 & 127]);
        else pass_cnt++;
        total_cnt++;
        if (word_cnt !== 16'd5) $display("FAIL flush_word_cnt: got %0d expected 5", word_cnt);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_read_error;
        int g0;
        logic [31:0] words;
        do_reset(8'h31, 5);
        err_mode = 1; err_sel = 1; en = 1'b1; m_ready = 1'b1; g0 = got_n;
        run_cycles(15);
        sample();
        words = {got_mem[g0 & 127], got_mem[(g0 + 1) & 127], got_mem[(g0 + 2) & 127], got_mem[(g0 + 3) & 127]};
        total_cnt++;
        if (got_n - g0 !== 4 || words !== 32'h31333435)
            $display("FAIL rderr_skip: got n=%0d words=%h expected n=4 words=31333435", got_n - g0, words);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt !== 16'd1 || word_cnt !== 16'd4) $display("FAIL rderr_counters: got e=%0d w=%0d expected 1 4", err_cnt, word_cnt);
        else pass_cnt++;
        next_cycle();
        do_reset(8'h51, 5);
        err_mode = 2; en = 1'b1; m_ready = 1'b1; g0 = got_n;
        run_cycles(15);
        sample();
        total_cnt++;
        if (err_cnt2 !== 2'd3) $display("FAIL rderr_saturate: got %0d expected 3", err_cnt2);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt !== 16'd5) $display("FAIL rderr_count5: got %0d expected 5", err_cnt);
        else pass_cnt++;
        total_cnt++;
        if (got_n - g0 !== 0 || m_valid !== 1'b0) $display("FAIL rderr_none_delivered: got n=%0d v=%b expected 0 0", got_n - g0, m_valid);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_enable_empty;
        int p0;
        int g0;
        logic [23:0] words;
        do_reset(8'h41, 8);
        en = 1'b1; m_ready = 1'b1; p0 = pop_cnt; g0 = got_n;
        next_cycle();
        en = 1'b0;
        sample();
        total_cnt++;
        if (fifo_rd_en !== 1'b0) $display("FAIL en_off_no_pop: got %b expected 0", fifo_rd_en);
        else pass_cnt++;
        run_cycles(8);
        sample();
        total_cnt++;
        if (pop_cnt - p0 !== 1 || got_n - g0 !== 1 || got_mem[g0 & 127] !== 8'h41)
            $display("FAIL en_inflight: got pops=%0d n=%0d first=%h expected 1 1 41", pop_cnt - p0, got_n - g0, got_mem[g0 & 127]);
        else pass_cnt++;
        next_cycle();
        m_ready = 1'b0; en = 1'b1;
        run_cycles(6);
        force_empty = 1'b1; m_ready = 1'b1; p0 = pop_cnt; g0 = got_n;
        run_cycles(10);
        sample();
        words = {got_mem[g0 & 127], got_mem[(g0 + 1) & 127], got_mem[(g0 + 2) & 127]};
        total_cnt++;
        if (pop_cnt - p0 !== 0) $display("FAIL empty_no_pop: got %0d pops expected 0", pop_cnt - p0);
        else pass_cnt++;
        total_cnt++;
        if (got_n - g0 !== 3 || words !== 24'h424344)
            $display("FAIL empty_drain: got n=%0d words=%h expected n=3 words=424344", got_n - g0, words);
        else pass_cnt++;
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL empty_valid_drop: got %b expected 0", m_valid);
        else pass_cnt++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_to_back_backpressure();
        test_flush();
        test_read_error();
        test_enable_empty();
        total_cnt++;
        if (underflow !== 0) $display("FAIL no_empty_pop: got %0d pops of an empty FIFO expected 0", underflow);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
